exe_div_unit: RTL and testbench

Multi-cycle integer divider for the EXE stage that implements RV32M DIV/DIVU/REM/REMU with radix-2 restoring division. It sits at the requesting end of the pipeline stall protocol. While a division is in flight it drives the EXE stall request into pipeline control. It consumes the resulting 6-bit stall vector and the jump flush, so it knows when its result has been accepted or must be discarded.

---
 rtl/exe_div_unit_pkg.sv | 41 ++++
 rtl/div_restore_step.sv | 41 ++++
 rtl/exe_div_unit.sv | 184 ++++++++++++++++++
 tb/tb_exe_div_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_div_unit_pkg.sv
// ============================================================================
// Module      : exe_div_unit_pkg
// Description : Shared constants for the EXE-stage divider: stall request
//               levels, divide op encodings, FSM state encodings,
//               stall-vector bit indices and a small sign helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exe_div_unit_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN + 1);

  // Stall request levels driven toward pipeline control
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Divide op encodings (op_in)
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Stall-vector bit indices
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;

  // Two's-complement negate when neg is set
  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_restore_step.sv
// ============================================================================
// Module      : div_restore_step
// Description : One combinational radix-2 restoring division iteration.
//               {rem,quo} is shifted left by one, the divisor is trial-
//               subtracted from the widened remainder, and the difference is
//               kept (quotient bit = 1) when it is non-negative.
// Revision    : 1.0 - initial release
// Ports       :
//   rem       in  WIDTH  partial remainder (always < divisor)
//   quo       in  WIDTH  partial quotient / remaining dividend bits
//   divisor   in  WIDTH  divisor magnitude
//   next_rem  out WIDTH  remainder after this step
//   next_quo  out WIDTH  quotient after this step
// ============================================================================
`default_nettype none

module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // rem < divisor on entry, so rem_sh < 2*divisor fits WIDTH+1 bits and the
  // MSB of the WIDTH+1-bit difference is a reliable borrow flag.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    trial    = rem_sh - {1'b0, divisor};
    next_rem = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    next_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

endmodule

`default_nettype wire

// File: rtl/exe_div_unit.sv
// ============================================================================
// Module      : exe_div_unit
// Description : Multi-cycle RV32M DIV/DIVU/REM/REMU unit for the EXE stage.
//               Restoring division, one bit per cycle. Requests a pipeline
//               stall while busy and watches the stall vector / jump flush
//               to know when its result is consumed or discarded.
// Revision    : 1.0 - initial release
// Ports       :
//   clk_in            in   1     clock, rising edge
//   reset_n_in        in   1     synchronous active-low reset
//   start_in          in   1     divide op occupies EXE
//   op_in             in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_in       in   XLEN  rs1 value
//   divisor_in        in   XLEN  rs2 value
//   stall_in          in   6     stall vector (bit2 ID_EX, bit3 EX_MEM)
//   flush_in          in   1     jump flush
//   stallreq_out      out  1     EXE stall request
//   result_out        out  XLEN  quotient or remainder
//   result_valid_out  out  1     result present this cycle
// ============================================================================
`default_nettype none

module exe_div_unit
  import exe_div_unit_pkg::*;
(
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            start_in,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] dividend_in,
  input  logic [XLEN-1:0] divisor_in,
  input  logic [5:0]      stall_in,
  input  logic            flush_in,
  output logic            stallreq_out,
  output logic [XLEN-1:0] result_out,
  output logic            result_valid_out
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [1:0]      next_state;
  logic            hold_q;
  logic [CNT_W-1:0] counter;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] divisor_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            is_signed_in;
  logic            is_rem_in;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN-1:0] dvd_mag;
  logic [XLEN-1:0] dvs_mag;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_result;
  logic            accept;
  logic            last_step;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] calc_result;

  // Stall bits owned by other stages are irrelevant here
  logic unused_stall;
  assign unused_stall = ^{stall_in[5:4], stall_in[1:0]};

  // --------------------------------------------------------------------------
  // Operand preparation for the accept cycle
  // --------------------------------------------------------------------------
  always_comb begin
    is_signed_in = (op_in == OP_DIV) || (op_in == OP_REM);
    is_rem_in    = (op_in == OP_REM) || (op_in == OP_REMU);
    dvd_neg      = is_signed_in & dividend_in[XLEN-1];
    dvs_neg      = is_signed_in & divisor_in[XLEN-1];
    dvd_mag      = neg_if(dvd_neg, dividend_in);
    dvs_mag      = neg_if(dvs_neg, divisor_in);
    div_zero     = (divisor_in == '0);
    overflow     = is_signed_in && (dividend_in == MIN_INT) && (divisor_in == '1);
    special      = div_zero | overflow;
    // Divide-by-zero returns the raw dividend as remainder, never sign-fixed
    if (div_zero) special_result = is_rem_in ? dividend_in : '1;
    else          special_result = is_rem_in ? '0 : MIN_INT;
    accept       = start_in && (state == ST_IDLE) && !hold_q && !flush_in;
    last_step    = (state == ST_CALC) && (counter == CNT_W'(1));
  end

  div_restore_step #(.WIDTH(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .next_rem (step_rem),
    .next_quo (step_quo)
  );

  // Sign fix applied to the final step's output so the result is ready on DONE entry
  always_comb begin
    if ((op_q == OP_REM) || (op_q == OP_REMU)) calc_result = neg_if(neg_rem_q, step_rem);
    else                                       calc_result = neg_if(neg_quo_q, step_quo);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) state <= ST_IDLE;
    else             state <= next_state;
  end

  // FSM: next-state logic
  always_comb begin
    next_state = state;
    if (flush_in) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept)    next_state = special ? ST_DONE : ST_CALC;
        ST_CALC: if (last_step) next_state = ST_DONE;
        ST_DONE: if (!stall_in[STALL_EX_MEM]) next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs. Stall request is combinational so it covers the accept cycle.
  always_comb begin
    stallreq_out     = NOSTOP;
    result_valid_out = 1'b0;
    if (!flush_in) begin
      case (state)
        ST_IDLE: if (start_in && !hold_q) stallreq_out = STOP;
        ST_CALC: stallreq_out = STOP;
        ST_DONE: result_valid_out = 1'b1;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath, counter and re-execution guard
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      hold_q     <= 1'b0;
      counter    <= '0;
      op_q       <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_out <= '0;
    end else begin
      // hold_q marks "the op still sitting in ID_EX was already executed"
      if (flush_in || !stall_in[STALL_ID_EX])
        hold_q <= 1'b0;
      else if ((state == ST_DONE) && !stall_in[STALL_EX_MEM])
        hold_q <= 1'b1;

      if (accept) begin
        op_q      <= op_in;
        rem_q     <= '0;
        quo_q     <= dvd_mag;
        divisor_q <= dvs_mag;
        neg_quo_q <= dvd_neg ^ dvs_neg;
        neg_rem_q <= dvd_neg;
        counter   <= CNT_W'(XLEN);
        if (special) result_out <= special_result;
      end else if ((state == ST_CALC) && !flush_in) begin
        rem_q   <= step_rem;
        quo_q   <= step_quo;
        counter <= counter - 1'b1;
        if (last_step) result_out <= calc_result;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exe_div_unit.sv
// ============================================================================
// Module      : tb_exe_div_unit
// Description : Self-checking bench for exe_div_unit: a table of divide
//               vectors plus hand-written flush/reset/hold sequences, with
//               expected results queued at issue and compared on output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_div_unit;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic [5:0]  stall_in;
  logic [5:0]  ext_stall;
  logic        flush_in;
  logic        stallreq_out;
  logic [31:0] result_out;
  logic        result_valid_out;

  // Simple pipeline control: an EXE stall request freezes PC..EX_MEM
  assign stall_in = stallreq_out ? 6'b001111 : ext_stall;

  always #5 clk_in = ~clk_in;

  exe_div_unit dut (
    .clk_in           (clk_in),
    .reset_n_in       (reset_n_in),
    .start_in         (start_in),
    .op_in            (op_in),
    .dividend_in      (dividend_in),
    .divisor_in       (divisor_in),
    .stall_in         (stall_in),
    .flush_in         (flush_in),
    .stallreq_out     (stallreq_out),
    .result_out       (result_out),
    .result_valid_out (result_valid_out)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(posedge clk_in); #1;
    start_in = 1'b1; op_in = op; dividend_in = a; divisor_in = b;
    exp_q.push_back(exp);
  endtask

  // Waits for result_valid, counting stall-request cycles; scrambles operands
  // after every edge to show they are only sampled on accept.
  task automatic wait_result(input string name, output int stalls);
    bit got;
    stalls = 0;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_in);
      if (result_valid_out) begin
        got = 1;
        break;
      end
      if (stallreq_out) stalls++;
      @(posedge clk_in); #1;
      dividend_in = $urandom; divisor_in = $urandom; op_in = 2'($urandom);
    end
    if (!got) check({name, "_timeout"}, 32'd0, 32'd1);
    else if (exp_q.size() == 0) check({name, "_unexpected_result"}, result_out, 32'hx);
    else check(name, result_out, exp_q.pop_front());
  endtask

  task automatic run_vec(input vec_t v);
    int stalls;
    issue(v.op, v.a, v.b, v.exp);
    wait_result(v.name, stalls);
    check({v.name, "_stalls"}, 32'(stalls), 32'(v.stalls));
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  // Counts result_valid pulses over n cycles (used after an abort)
  task automatic quiet_cycles(input int n, output int seen);
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk_in);
      if (result_valid_out) seen++;
    end
  endtask

  initial begin
    int stalls;
    int seen;

    vecs[0]  = '{"divu_100_7",  2'b01, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{"remu_100_7",  2'b11, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{"div_m7_2",    2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33};
    vecs[3]  = '{"rem_m7_2",    2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33};
    vecs[4]  = '{"div_5_0",     2'b00, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
    vecs[5]  = '{"rem_5_0",     2'b10, 32'd5,          32'd0,          32'd5,          1};
    vecs[6]  = '{"divu_5_0",    2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
    vecs[7]  = '{"rem_m5_0",    2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1};
    vecs[8]  = '{"div_ovf",     2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
    vecs[9]  = '{"rem_ovf",     2'b10, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
    vecs[10] = '{"divu_big",    2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33};
    vecs[11] = '{"remu_big",    2'b11, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33};
    vecs[12] = '{"div_7_m2",    2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   33};
    vecs[13] = '{"rem_7_m2",    2'b10, 32'd7,          32'hFFFFFFFE,   32'd1,          33};
    vecs[14] = '{"div_m8_m3",   2'b00, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          33};
    vecs[15] = '{"rem_m8_m3",   2'b10, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'hFFFFFFFE,   33};
    vecs[16] = '{"divu_max_1",  2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   33};
    vecs[17] = '{"remu_max_16", 2'b11, 32'hFFFFFFFF,   32'd16,         32'd15,         33};

    reset_n_in = 1'b0; start_in = 1'b0; op_in = 2'b00;
    dividend_in = '0; divisor_in = '0; ext_stall = '0; flush_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    check("reset_stallreq", {31'd0, stallreq_out}, 32'd0);
    check("reset_valid",    {31'd0, result_valid_out}, 32'd0);
    check("reset_result",   result_out, 32'd0);
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // DONE held by EX_MEM stall, then exit while ID_EX still holds the op
    issue(2'b01, 32'd1000, 32'd10, 32'd100);
    wait_result("hold_first", stalls);
    ext_stall = 6'b001100;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_in); #1;
      @(negedge clk_in);
      check("hold_valid",  {31'd0, result_valid_out}, 32'd1);
      check("hold_result", result_out, 32'd100);
    end
    ext_stall = 6'b000100;
    dividend_in = 32'd1000; divisor_in = 32'd10; op_in = 2'b01;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_in); #1;
      @(negedge clk_in);
      check("no_reaccept_stallreq", {31'd0, stallreq_out}, 32'd0);
      check("no_reaccept_valid",    {31'd0, result_valid_out}, 32'd0);
    end
    ext_stall = 6'b000000;
    exp_q.push_back(32'd100);
    wait_result("reaccept", stalls);
    check("reaccept_stalls", 32'(stalls), 32'd33);
    @(posedge clk_in); #1;
    start_in = 1'b0;

    // Flush mid-CALC
    @(posedge clk_in); #1;
    start_in = 1'b1; op_in = 2'b01; dividend_in = 32'd100; divisor_in = 32'd7;
    repeat (11) @(posedge clk_in);
    #1;
    flush_in = 1'b1; start_in = 1'b0;
    @(negedge clk_in);
    check("flush_stallreq_forced", {31'd0, stallreq_out}, 32'd0);
    @(posedge clk_in); #1;
    flush_in = 1'b0;
    @(negedge clk_in);
    check("flush_idle_stallreq", {31'd0, stallreq_out}, 32'd0);
    quiet_cycles(40, seen);
    check("flush_no_result", 32'(seen), 32'd0);

    // Reset mid-CALC (result_out currently holds a nonzero earlier result)
    @(posedge clk_in); #1;
    start_in = 1'b1; op_in = 2'b00; dividend_in = 32'd12345; divisor_in = 32'd3;
    repeat (11) @(posedge clk_in);
    #1;
    reset_n_in = 1'b0; start_in = 1'b0;
    @(posedge clk_in); #1;
    reset_n_in = 1'b1;
    @(negedge clk_in);
    check("rst_mid_stallreq", {31'd0, stallreq_out}, 32'd0);
    check("rst_mid_valid",    {31'd0, result_valid_out}, 32'd0);
    check("rst_mid_result",   result_out, 32'd0);
    quiet_cycles(40, seen);
    check("rst_no_result", 32'(seen), 32'd0);

    // Recovery after the aborts
    run_vec(vecs[0]);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
